pdm_sdm2_tx: RTL

- PCM-to-PDM transmitter: accepts signed 16-bit PCM samples via valid/ready handshake and emits a 1-bit PDM stream, one bit per clk.
- Pairs with the CIC3 PDM decimator on the receive side: same clock domain (clk = PDM bit clock), same OSR of 64.
- Datapath: one-entry sample holding register, then sample interpolator (zero-order hold by default), then 2nd-order sigma-delta modulator.
- Output drives a PDM speaker/DAC pin, or loops back to the decimator in test.

---
 rtl/pdm_pkg.sv | 22 ++
 rtl/pdm_sdm2.sv | 78 +++++++
 rtl/pdm_sdm2_tx.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/pdm_pkg.sv
// pdm_pkg: constants and types shared by the PDM transmitter and the CIC3 decimator.
// Latency: n/a (declarations only).
// Backpressure: n/a.
//
// Contents:
//   PDM_OSR        PDM bits per PCM sample (power of 2)
//   PCM_W          PCM sample width, signed two's complement
//   FS             full-scale magnitude, 2^(PCM_W-1)
//   CLAMP_DEFAULT  input magnitude limit (7/8 full scale) that keeps the modulator loop bounded
//   ACC_W_DEFAULT  integrator width used by the sigma-delta core
//   pcm_t          signed PCM_W-bit sample type
package pdm_pkg;

  localparam int PDM_OSR       = 64;
  localparam int PCM_W         = 16;
  localparam int FS            = 2 ** (PCM_W - 1);
  localparam int CLAMP_DEFAULT = 28672;
  localparam int ACC_W_DEFAULT = 24;

  typedef logic signed [PCM_W-1:0] pcm_t;

endpackage

// File: rtl/pdm_sdm2.sv
// pdm_sdm2: 2nd-order sigma-delta modulator core, one PDM bit per clk.
// Latency: x reaches i1 on the next edge; pdm_out is the registered sign of i2.
// Backpressure: none; consumes x every cycle unconditionally.
//
// Ports:
//   clk      PDM bit clock, posedge
//   rst_n    asynchronous active-low reset (i1 = i2 = 0, pdm_out = 0)
//   x        signed IN_W-bit modulator input
//   pdm_out  registered PDM bit
module pdm_sdm2 #(
  parameter int IN_W  = 16,
  parameter int ACC_W = 24
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic signed [IN_W-1:0] x,
  output logic                   pdm_out
);

  // Two guard bits above ACC_W hold any i + x - fb sum without wrapping,
  // so overflow can be detected and saturated instead.
  localparam int SW = ACC_W + 2;
  localparam logic signed [SW-1:0] FB_MAG = SW'(2 ** (IN_W - 1));

  logic signed [ACC_W-1:0] r_i1;
  logic signed [ACC_W-1:0] r_i2;
  logic                    r_pdm;

  logic signed [SW-1:0]    w_fb;
  logic signed [SW-1:0]    w_x_ext;
  logic signed [SW-1:0]    w_i1_ext;
  logic signed [SW-1:0]    w_i2_ext;
  logic signed [SW-1:0]    w_sum1;
  logic signed [SW-1:0]    w_sum2;
  logic signed [ACC_W-1:0] w_i1_nxt;
  logic signed [ACC_W-1:0] w_i2_nxt;

  // Clip a guarded sum to the signed ACC_W range. The sum fits when the
  // three top bits (two guards plus the ACC_W sign) all agree.
  function automatic logic signed [ACC_W-1:0] sat(input logic signed [SW-1:0] v);
    logic [2:0] top;
    top = v[SW-1:ACC_W-1];
    if (top == 3'b000 || top == 3'b111) begin
      sat = v[ACC_W-1:0];
    end else if (v[SW-1]) begin
      sat = {1'b1, {(ACC_W-1){1'b0}}};
    end else begin
      sat = {1'b0, {(ACC_W-1){1'b1}}};
    end
  endfunction

  assign w_fb     = r_pdm ? FB_MAG : -FB_MAG;
  assign w_x_ext  = SW'(x);
  assign w_i1_ext = SW'(r_i1);
  assign w_i2_ext = SW'(r_i2);

  assign w_sum1   = w_i1_ext + w_x_ext - w_fb;
  // Second stage integrates the pre-update i1.
  assign w_sum2   = w_i2_ext + w_i1_ext - w_fb;
  assign w_i1_nxt = sat(w_sum1);
  assign w_i2_nxt = sat(w_sum2);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_i1  <= '0;
      r_i2  <= '0;
      r_pdm <= 1'b0;
    end else begin
      r_i1  <= w_i1_nxt;
      r_i2  <= w_i2_nxt;
      // Quantise the current i2, not the value being written this edge.
      r_pdm <= ~r_i2[ACC_W-1];
    end
  end

  assign pdm_out = r_pdm;

endmodule

// File: rtl/pdm_sdm2_tx.sv
// pdm_sdm2_tx: PCM-to-PDM transmitter (holding register, phase counter, clamp, interpolator, SDM2 core).
// Latency: an accepted sample reaches the modulator at the next load point (worst case OSR+1 cycles).
// Backpressure: pcm_ready = !full; a one-entry holding register is drained only at the load point.
//
// Ports:
//   clk          PDM bit clock, posedge
//   rst_n        asynchronous active-low reset; discards any held sample
//   pcm_in       signed IN_W-bit PCM sample
//   pcm_valid    pcm_in valid this cycle
//   pcm_ready    holding register empty (combinational)
//   pdm_out      registered PDM bit
//   sample_tick  one-cycle pulse after a load point that consumed a sample
//   underrun     one-cycle pulse after a load point that found no sample
//
// Build option: define PDM_TX_INTERP_LINEAR_EN to replace zero-order hold with
// linear interpolation between consecutive samples. Ports and latency are unchanged.
module pdm_sdm2_tx
  import pdm_pkg::*;
#(
  parameter int OSR   = PDM_OSR,
  parameter int IN_W  = PCM_W,
  parameter int ACC_W = ACC_W_DEFAULT,
  parameter int CLAMP = CLAMP_DEFAULT
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic signed [IN_W-1:0] pcm_in,
  input  logic                   pcm_valid,
  output logic                   pcm_ready,
  output logic                   pdm_out,
  output logic                   sample_tick,
  output logic                   underrun
);

  localparam int                     PH_W      = $clog2(OSR);
  localparam logic [PH_W-1:0]        PH_LAST   = PH_W'(OSR - 1);
  localparam logic [PH_W-1:0]        PH_ONE    = PH_W'(1);
  localparam logic signed [IN_W-1:0] CLAMP_POS = IN_W'(CLAMP);
  localparam logic signed [IN_W-1:0] CLAMP_NEG = IN_W'(-CLAMP);

  logic [PH_W-1:0]        r_phase;
  logic                   r_full;
  logic signed [IN_W-1:0] r_held;
  logic signed [IN_W-1:0] r_cur;
  logic                   r_tick;
  logic                   r_und;

  logic                   w_accept;
  logic                   w_load;
  logic signed [IN_W-1:0] w_clamped;
  logic signed [IN_W-1:0] w_x;

  assign pcm_ready = ~r_full;
  assign w_accept  = pcm_valid & ~r_full;
  assign w_load    = (r_phase == PH_LAST);

  always_comb begin
    w_clamped = r_held;
    if (r_held > CLAMP_POS) begin
      w_clamped = CLAMP_POS;
    end else if (r_held < CLAMP_NEG) begin
      w_clamped = CLAMP_NEG;
    end
  end

  // OSR is a power of two, so the counter wraps to 0 on its own.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_phase <= '0;
    end else begin
      r_phase <= r_phase + PH_ONE;
    end
  end

  // Holding register. An accept only happens while empty, so it never races
  // the load point's clear: when both fall in one cycle the new sample wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_full <= 1'b0;
      r_held <= '0;
    end else if (w_accept) begin
      r_full <= 1'b1;
      r_held <= pcm_in;
    end else if (w_load) begin
      r_full <= 1'b0;
    end
  end

  // Load point: move the held sample into the modulator, or repeat the last
  // one and flag underrun. No bypass from pcm_in.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cur  <= '0;
      r_tick <= 1'b0;
      r_und  <= 1'b0;
    end else begin
      r_tick <= w_load & r_full;
      r_und  <= w_load & ~r_full;
      if (w_load && r_full) begin
        r_cur <= w_clamped;
      end
    end
  end

`ifdef PDM_TX_INTERP_LINEAR_EN
  // Linear ramp from the previous target to the new one. At each load x is
  // snapped to the previous target exactly, discarding the truncation residual
  // of the last ramp, and a fresh step is computed.
  localparam int LOG2_OSR = $clog2(OSR);

  logic signed [IN_W:0] r_x;
  logic signed [IN_W:0] r_step;
  logic signed [IN_W:0] w_cur_ext;
  logic signed [IN_W:0] w_new_ext;
  logic signed [IN_W:0] w_diff;

  assign w_cur_ext = {r_cur[IN_W-1], r_cur};
  assign w_new_ext = {w_clamped[IN_W-1], w_clamped};
  assign w_diff    = w_new_ext - w_cur_ext;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_x    <= '0;
      r_step <= '0;
    end else if (w_load) begin
      r_x    <= w_cur_ext;
      r_step <= r_full ? (w_diff >>> LOG2_OSR) : '0;
    end else begin
      r_x    <= r_x + r_step;
    end
  end

  // The ramp stays between two in-range samples, so the top bit is redundant.
  assign w_x = r_x[IN_W-1:0];
`else
  assign w_x = r_cur;
`endif

  pdm_sdm2 #(
    .IN_W  (IN_W),
    .ACC_W (ACC_W)
  ) u_sdm2 (
    .clk     (clk),
    .rst_n   (rst_n),
    .x       (w_x),
    .pdm_out (pdm_out)
  );

  assign sample_tick = r_tick;
  assign underrun    = r_und;

endmodule
